load_ud_counter: RTL

Parametrised successor to the 4-bit loadable counter. Up/down counter with synchronous load, count enable, programmable upper limit, and three run modes: wrap, saturate and one-shot. It produces a terminal-count pulse and a one-shot done flag. It serves as the general timer/counter primitive for the COUNTER collection.

---
 rtl/load_ud_pkg.sv | 43 ++++
 rtl/load_ud_prescale.sv | 36 +++
 rtl/load_ud_counter.sv | 115 +++++++++++
 3 files changed

// File: rtl/load_ud_pkg.sv
// Shared types and step arithmetic for the loadable up/down counter.
package load_ud_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] count;
        logic        term;
        logic        held;
    } step_t;

    // held marks a clamped step (SAT/ONESHOT already at the terminal value)
    function automatic step_t next_count(input logic [31:0] cur,
                                         input logic        dir,
                                         input mode_e       mode,
                                         input logic [31:0] max);
        step_t       r;
        logic [31:0] term_val;
        term_val = dir ? max : 32'd0;
        r.held   = 1'b0;
        if (cur == term_val && mode == MODE_WRAP) begin
            r.count = dir ? 32'd0 : max;
        end else if (cur == term_val) begin
            r.count = cur;
            r.held  = 1'b1;
        end else begin
            r.count = dir ? cur + 32'd1 : cur - 32'd1;
        end
        r.term = (r.count == term_val);
        return r;
    endfunction

endpackage

// File: rtl/load_ud_prescale.sv
// Enable prescaler: down-counter that yields one tick per PRESCALE enabled cycles.
module load_ud_prescale #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int             PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0]  RELOAD = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - PW'(1);
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/load_ud_counter.sv
// Loadable up/down counter with WRAP/SAT/ONESHOT modes and terminal-count pulse.
// Optional enable prescaler built when LOAD_UD_PRESCALE_EN is defined.
//
// state   | meaning
// ST_IDLE | not in a one-shot run; count only moves in WRAP/SAT
// ST_RUN  | one-shot run active, busy_o high
// ST_DONE | one-shot reached terminal value, done_o high until next load
module load_ud_counter
    import load_ud_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             done_o,
    output logic             busy_o
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             tick;
    logic             step;
    mode_e            mode;
    step_t            nc;
    logic [31-WIDTH:0] unused_hi;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

`ifdef LOAD_UD_PRESCALE_EN
    load_ud_prescale #(.PRESCALE(PRESCALE)) u_prescale (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .clr_i  (load_i),
        .tick_o (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    assign step      = en_i && tick;
    assign mode      = (mode_i == 2'd3) ? MODE_WRAP : mode_e'(mode_i);
    assign nc        = next_count(32'(count_q), dir_i, mode, 32'(MAX_W));
    assign unused_hi = nc.count[31:WIDTH];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        busy_d  = busy_q;
        if (load_i) begin
            count_d = (load_val_i > MAX_W) ? MAX_W : load_val_i;
            done_d  = 1'b0;
            state_d = (mode == MODE_ONESHOT) ? ST_RUN : ST_IDLE;
            busy_d  = (mode == MODE_ONESHOT);
        end else begin
            if (mode != MODE_ONESHOT) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            if (step) begin
                if (mode != MODE_ONESHOT) begin
                    count_d = nc.count[WIDTH-1:0];
                    tc_d    = nc.term && !nc.held;
                end else if (state_q == ST_RUN) begin
                    // a run loaded at the terminal value finishes here with no count change
                    count_d = nc.count[WIDTH-1:0];
                    tc_d    = nc.term;
                    if (nc.term) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

endmodule
